// File: rtl/wave_seq_player.sv
// Segment-table waveform player: plays a list of (level, duration) hold segments
// to the printhead DAC for a one-hot request and answers with a one-cycle wave_end.
module wave_seq_player #(
    parameter int DAC_W  = 12,
    parameter int DUR_W  = 16,
    parameter int SEG_N  = 8,
    parameter int WAVE_N = 12
) (
    input  logic                   clk,
    input  logic                   rstn,
    // Request protocol: wave_req is a one-cycle pulse with wave_sel valid in the
    // same cycle. It is accepted only while busy is low; every accepted request
    // (good or bad select) is answered by exactly one wave_end pulse unless reset
    // intervenes. Requests while busy are dropped and flagged on seq_err.
    input  logic                   wave_req,
    input  logic [WAVE_N-1:0]      wave_sel,
    input  logic                   abort,
    input  logic                   cfg_we,
    input  logic [6:0]             cfg_addr,
    input  logic [DUR_W+DAC_W-1:0] cfg_wdata,
    output logic [DAC_W-1:0]       dac_data,
    output logic                   dac_valid,
    output logic                   wave_end,
    output logic                   busy,
    output logic [3:0]             cur_wave,
    output logic                   seq_err,
    output logic [1:0]             err_code,
    // Debug view of the sequencer: 0 IDLE, 1 LOAD, 2 PLAY, 3 DONE.
    output logic [1:0]             fsm_state
);

    localparam int SEG_W = $clog2(SEG_N);
    localparam int CNT_W = $clog2(WAVE_N + 1);

    localparam logic [1:0] ERR_BUSY  = 2'd1;
    localparam logic [1:0] ERR_SEL   = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    logic [SEG_W-1:0] seg;
    logic [DUR_W-1:0] cnt;

    logic [DUR_W-1:0] tbl_dur [WAVE_N][SEG_N];
    logic [DAC_W-1:0] tbl_lvl [WAVE_N][SEG_N];

    logic [3:0]       wr_wave;
    logic [SEG_W-1:0] wr_seg;
    logic             wr_ok;

    logic [CNT_W-1:0] sel_cnt;
    logic [3:0]       sel_idx;
    logic             sel_ok;

    logic [SEG_W-1:0] seg_nxt;
    logic [SEG_W-1:0] rd_seg;
    logic             seg_last;
    logic [DUR_W-1:0] rd_dur;
    logic [DAC_W-1:0] rd_lvl;

    assign fsm_state = state;

    assign wr_wave = cfg_addr[6:3];
    assign wr_seg  = cfg_addr[SEG_W-1:0];
    assign wr_ok   = int'(wr_wave) < WAVE_N;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int w = 0; w < WAVE_N; w++) begin
                for (int s = 0; s < SEG_N; s++) begin
                    tbl_dur[w][s] <= '0;
                    tbl_lvl[w][s] <= '0;
                end
            end
        end else if (cfg_we && wr_ok) begin
            tbl_dur[wr_wave][wr_seg] <= cfg_wdata[DUR_W+DAC_W-1:DAC_W];
            tbl_lvl[wr_wave][wr_seg] <= cfg_wdata[DAC_W-1:0];
        end
    end

    always_comb begin
        sel_cnt = '0;
        sel_idx = '0;
        for (int i = 0; i < WAVE_N; i++) begin
            if (wave_sel[i]) begin
                sel_cnt = sel_cnt + CNT_W'(1);
                sel_idx = 4'(i);
            end
        end
    end

    assign sel_ok = (sel_cnt == CNT_W'(1));

    // LOAD reads the current segment; PLAY looks ahead to the next one so the
    // following level is loaded on the same edge the current one expires.
    assign seg_nxt  = seg + SEG_W'(1);
    assign seg_last = (seg == SEG_W'(SEG_N - 1));
    assign rd_seg   = (state == S_LOAD) ? seg : seg_nxt;
    assign rd_dur   = tbl_dur[cur_wave][rd_seg];
    assign rd_lvl   = tbl_lvl[cur_wave][rd_seg];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            seg       <= '0;
            cnt       <= '0;
            dac_data  <= '0;
            dac_valid <= 1'b0;
            wave_end  <= 1'b0;
            busy      <= 1'b0;
            cur_wave  <= '0;
            seq_err   <= 1'b0;
            err_code  <= '0;
        end else begin
            seq_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wave_req) begin
                        busy <= 1'b1;
                        if (sel_ok) begin
                            cur_wave <= sel_idx;
                            seg      <= '0;
                            state    <= S_LOAD;
                        end else begin
                            state    <= S_DONE;
                            wave_end <= 1'b1;
                            seq_err  <= 1'b1;
                            err_code <= ERR_SEL;
                        end
                    end
                end
                S_LOAD, S_PLAY: begin
                    if (abort) begin
                        state     <= S_DONE;
                        wave_end  <= 1'b1;
                        dac_valid <= 1'b0;
                        seq_err   <= 1'b1;
                        err_code  <= ERR_ABORT;
                    end else begin
                        if (wave_req) begin
                            seq_err  <= 1'b1;
                            err_code <= ERR_BUSY;
                        end
                        if (state == S_PLAY && cnt != '0) begin
                            cnt <= cnt - DUR_W'(1);
                        end else if (rd_dur == '0 || (state == S_PLAY && seg_last)) begin
                            state     <= S_DONE;
                            wave_end  <= 1'b1;
                            dac_valid <= 1'b0;
                        end else begin
                            if (state == S_PLAY) begin
                                seg <= seg_nxt;
                            end
                            dac_data  <= rd_lvl;
                            dac_valid <= 1'b1;
                            cnt       <= rd_dur - DUR_W'(1);
                            state     <= S_PLAY;
                        end
                    end
                end
                S_DONE: begin
                    wave_end  <= 1'b0;
                    dac_data  <= '0;
                    dac_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                    if (wave_req) begin
                        seq_err  <= 1'b1;
                        err_code <= ERR_BUSY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_seq_player.sv
// Bench for wave_seq_player: directed scenarios plus randomized waveforms checked
// cycle by cycle against a table model that expands segments into a level trace.
module tb_wave_seq_player;

    localparam int DAC_W  = 12;
    localparam int DUR_W  = 16;
    localparam int SEG_N  = 8;
    localparam int WAVE_N = 12;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   wave_req = 1'b0;
    logic [WAVE_N-1:0]      wave_sel = '0;
    logic                   abort = 1'b0;
    logic                   cfg_we = 1'b0;
    logic [6:0]             cfg_addr = '0;
    logic [DUR_W+DAC_W-1:0] cfg_wdata = '0;
    logic [DAC_W-1:0]       dac_data;
    logic                   dac_valid;
    logic                   wave_end;
    logic                   busy;
    logic [3:0]             cur_wave;
    logic                   seq_err;
    logic [1:0]             err_code;
    logic [1:0]             fsm_state;

    wave_seq_player #(
        .DAC_W(DAC_W), .DUR_W(DUR_W), .SEG_N(SEG_N), .WAVE_N(WAVE_N)
    ) dut (
        .clk(clk), .rstn(rstn), .wave_req(wave_req), .wave_sel(wave_sel),
        .abort(abort), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .dac_data(dac_data), .dac_valid(dac_valid), .wave_end(wave_end),
        .busy(busy), .cur_wave(cur_wave), .seq_err(seq_err), .err_code(err_code),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: table contents, last latched waveform and last error.
    int dur_m [WAVE_N][SEG_N];
    int lvl_m [WAVE_N][SEG_N];
    int cw_m  = 0;
    int err_m = 0;
    logic [DAC_W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int w = 0; w < WAVE_N; w++) begin
            for (int s = 0; s < SEG_N; s++) begin
                dur_m[w][s] = 0;
                lvl_m[w][s] = 0;
            end
        end
        cw_m  = 0;
        err_m = 0;
    endtask

    task automatic write_cfg(input int w, input int s, input int dur, input int lvl);
        cfg_we    = 1'b1;
        cfg_addr  = 7'((w << 3) | s);
        cfg_wdata = {DUR_W'(dur), DAC_W'(lvl)};
        @(negedge clk);
        cfg_we = 1'b0;
        if (w < WAVE_N) begin
            dur_m[w][s] = dur;
            lvl_m[w][s] = lvl;
        end
    endtask

    // Expand the segment list into the level seen on each playing cycle.
    task automatic build_trace(input int w);
        exp_q.delete();
        for (int s = 0; s < SEG_N; s++) begin
            if (dur_m[w][s] == 0) break;
            for (int d = 0; d < dur_m[w][s]; d++) exp_q.push_back(DAC_W'(lvl_m[w][s]));
        end
    endtask

    // Request waveform w now (cycle T); offsets k below are cycles after T.
    // req_at/abort_at/wr_at of -1 mean none. The mid-play write must land before
    // the written segment is reached, so the model applies it up front.
    task automatic run_wave(input int w, input int req_at, input int abort_at,
                            input int wr_at, input int wr_seg, input int wr_dur, input int wr_lvl);
        int n;
        int end_k;
        logic [WAVE_N-1:0] one;
        one = 1;
        if (wr_at >= 1) begin
            dur_m[w][wr_seg] = wr_dur;
            lvl_m[w][wr_seg] = wr_lvl;
        end
        build_trace(w);
        n = exp_q.size();
        end_k = (abort_at >= 1) ? abort_at + 1 : n + 2;
        wave_req = 1'b1;
        wave_sel = one << w;
        for (int k = 1; k <= end_k + 1; k++) begin
            @(negedge clk);
            if (k == 1) cw_m = w;
            if (k == req_at + 1) err_m = 1;
            if (k == abort_at + 1) err_m = 3;
            if (k < end_k) begin
                check_eq("play_valid", dac_valid, k >= 2);
                check_eq("play_data", dac_data, (k >= 2) ? exp_q[k-2] : '0);
                check_eq("play_busy", busy, 1);
                check_eq("play_end", wave_end, 0);
            end else if (k == end_k) begin
                check_eq("end_pulse", wave_end, 1);
                check_eq("end_valid", dac_valid, 0);
                check_eq("end_busy", busy, 1);
            end else begin
                check_eq("post_end", wave_end, 0);
                check_eq("post_valid", dac_valid, 0);
                check_eq("post_busy", busy, 0);
                check_eq("post_data", dac_data, 0);
            end
            check_eq("seq_err", seq_err, (k == req_at + 1) || (k == abort_at + 1));
            check_eq("err_code", err_code, err_m);
            check_eq("cur_wave", cur_wave, cw_m);
            wave_req = (k == req_at);
            wave_sel = (k == req_at) ? (one << $urandom_range(0, WAVE_N - 1)) : '0;
            abort    = (k == abort_at);
            cfg_we   = (k == wr_at);
            cfg_addr = 7'((w << 3) | wr_seg);
            cfg_wdata = {DUR_W'(wr_dur), DAC_W'(wr_lvl)};
        end
        wave_req = 1'b0;
        wave_sel = '0;
        abort    = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic bad_sel(input logic [WAVE_N-1:0] sel);
        wave_req = 1'b1;
        wave_sel = sel;
        @(negedge clk);
        wave_req = 1'b0;
        wave_sel = '0;
        err_m = 2;
        check_eq("bad_end", wave_end, 1);
        check_eq("bad_seq_err", seq_err, 1);
        check_eq("bad_code", err_code, err_m);
        check_eq("bad_valid", dac_valid, 0);
        check_eq("bad_cur_wave", cur_wave, cw_m);
        @(negedge clk);
        check_eq("bad_after_end", wave_end, 0);
        check_eq("bad_after_err", seq_err, 0);
        check_eq("bad_after_busy", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_data"}, dac_data, 0);
        check_eq({tag, "_valid"}, dac_valid, 0);
        check_eq({tag, "_end"}, wave_end, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_cur_wave"}, cur_wave, 0);
        check_eq({tag, "_seq_err"}, seq_err, 0);
        check_eq({tag, "_err_code"}, err_code, 0);
    endtask

    function automatic int trace_len(input int w);
        int t;
        t = 0;
        for (int s = 0; s < SEG_N; s++) begin
            if (dur_m[w][s] == 0) break;
            t += dur_m[w][s];
        end
        return t;
    endfunction

    initial begin
        clear_model();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        check_eq("reset_state", fsm_state, 0);
        rstn = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset");

        // Print waveform: two segments then an end marker.
        write_cfg(3, 0, 3, 'h100);
        write_cfg(3, 1, 2, 'h800);
        write_cfg(3, 2, 0, 0);
        run_wave(3, -1, -1, -1, 0, 0, 0);

        // Up waveform fills all segments, no marker.
        for (int s = 0; s < SEG_N; s++) write_cfg(2, s, 1, s + 1);
        run_wave(2, -1, -1, -1, 0, 0, 0);

        // Out-of-range wave index write is dropped; poweron stays empty.
        write_cfg(12, 0, 5, 'h7);
        run_wave(0, -1, -1, -1, 0, 0, 0);
        bad_sel(12'h009);
        bad_sel(12'h000);

        // Request during PLAY is ignored, then a back-to-back request is taken.
        run_wave(3, 3, -1, -1, 0, 0, 0);
        run_wave(3, -1, -1, -1, 0, 0, 0);

        // Mid-play rewrite of segment 1 takes effect when it is reached.
        write_cfg(5, 0, 6, 'h010);
        write_cfg(5, 1, 3, 'h020);
        write_cfg(5, 2, 0, 0);
        run_wave(5, -1, -1, 3, 1, 3, 'h3FF);

        // Abort while segment 0 (dur 100) is at count 40.
        write_cfg(4, 0, 100, 'h555);
        write_cfg(4, 1, 0, 0);
        run_wave(4, -1, 61, -1, 0, 0, 0);

        // Asynchronous reset in the middle of PLAY.
        wave_req = 1'b1;
        wave_sel = 12'h008;
        @(negedge clk);
        wave_req = 1'b0;
        wave_sel = '0;
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rstn = 1'b1;
        clear_model();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("reset_no_end", wave_end, 0);
            check_eq("reset_idle", busy, 0);
        end
        run_wave(3, -1, -1, -1, 0, 0, 0);

        // Randomized tables, requests-while-busy and aborts.
        for (int it = 0; it < 30; it++) begin
            int w;
            int nseg;
            int n;
            int end_k;
            int req_at;
            int abort_at;
            w = $urandom_range(0, WAVE_N - 1);
            nseg = $urandom_range(0, SEG_N);
            for (int s = 0; s < nseg; s++) write_cfg(w, s, $urandom_range(1, 4), $urandom_range(0, 4095));
            if (nseg < SEG_N) write_cfg(w, nseg, 0, $urandom_range(0, 4095));
            n = trace_len(w);
            abort_at = -1;
            if (n > 0 && $urandom_range(0, 3) == 0) abort_at = $urandom_range(1, n + 1);
            end_k = (abort_at >= 1) ? abort_at + 1 : n + 2;
            req_at = -1;
            if ($urandom_range(0, 2) == 0) req_at = $urandom_range(1, end_k);
            if (req_at == abort_at) req_at = -1;
            run_wave(w, req_at, abort_at, -1, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
